// File: rtl/imem_fetch_queue.sv
// Instruction prefetch queue: issues sequential word addresses to imem, buffers
// returned words with their PC, and hands them to decode over valid/ready.
module imem_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [31:0]              address_imem,
    input  logic [31:0]              q_imem,
    output logic                     fetch_valid,
    output logic [31:0]              fetch_insn,
    output logic [31:0]              fetch_pc,
    input  logic                     fetch_ready,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      next_pc;
    logic             req_pending;
    logic [31:0]      req_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [31:0]      mem_insn [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             capture;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

    // Every in-flight request holds a reserved slot, so a capture can never
    // find the buffer full; a same-cycle pop is deliberately not credited.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(req_pending);
    assign issue     = (occupancy < (CNT_W + 1)'(DEPTH)) && !redirect;
    assign capture   = req_pending && !redirect;
    assign pop       = fetch_valid && fetch_ready && !redirect;

    always_ff @(posedge clock) begin
        if (!reset) begin
            next_pc     <= 32'd0;
            req_pending <= 1'b0;
            req_pc      <= 32'd0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect) begin
            next_pc     <= redirect_pc;
            req_pending <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            if (issue) begin
                req_pending <= 1'b1;
                req_pc      <= next_pc;
                next_pc     <= pc_inc(next_pc);
            end else begin
                req_pending <= 1'b0;
            end
            if (capture)
                tail <= ptr_inc(tail);
            if (pop)
                head <= ptr_inc(head);
            case ({capture, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset && capture) begin
            mem_insn[tail] <= q_imem;
            mem_pc[tail]   <= req_pc;
        end
    end

    assign address_imem = next_pc;
    assign fetch_valid  = (count != '0);
    assign fetch_insn   = mem_insn[head];
    assign fetch_pc     = mem_pc[head];

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Self-checking bench for imem_fetch_queue: directed vector table, hand-written
// redirect/reset/wrap sequences, and a randomized run against a queue model.
module tb_imem_fetch_queue;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [31:0] address_imem;
    logic [31:0] q_imem;
    logic        fetch_valid;
    logic [31:0] fetch_insn;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int checks;
    int failures;

    imem_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .address_imem(address_imem),
        .q_imem(q_imem),
        .fetch_valid(fetch_valid),
        .fetch_insn(fetch_insn),
        .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // imem: one-cycle synchronous read returning a recognisable pattern
    always @(posedge clock) q_imem <= 32'hA000_0000 + address_imem;

    // Reference model: the buffer is a plain queue of PCs; the word for a PC
    // is always the imem pattern, so only PCs need to be tracked.
    logic [31:0] mq[$];
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_npc;

    task automatic model_update();
        bit do_issue;
        bit do_pop;
        if (!reset) begin
            mq.delete();
            m_pend = 1'b0;
            m_npc  = 32'd0;
        end else if (redirect) begin
            mq.delete();
            m_pend = 1'b0;
            m_npc  = redirect_pc;
        end else begin
            do_issue = (mq.size() + int'(m_pend)) < DEPTH;
            do_pop   = (mq.size() != 0) && fetch_ready;
            if (do_pop) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
            if (do_issue) begin
                m_pend    = 1'b1;
                m_pend_pc = m_npc;
                m_npc     = m_npc + 32'd1;
            end else begin
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_check();
        chk("model_valid", {31'd0, fetch_valid}, {31'd0, mq.size() != 0});
        chk("model_count", {29'd0, count}, 32'(mq.size()));
        chk("model_addr", address_imem, m_npc);
        if (mq.size() != 0) begin
            chk("model_pc", fetch_pc, mq[0]);
            chk("model_insn", fetch_insn, 32'hA000_0000 + mq[0]);
        end
    endtask

    // One clock: advance model with the inputs seen at the edge, then check.
    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        model_check();
    endtask

    task automatic drive(input logic rst_n, input logic redir, input logic [31:0] rpc,
                         input logic rdy);
        reset       = rst_n;
        redirect    = redir;
        redirect_pc = rpc;
        fetch_ready = rdy;
    endtask

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_count;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic redir, input logic [31:0] rpc,
                                input logic rdy, input logic ev, input logic [2:0] ec,
                                input logic [31:0] epc, input logic [31:0] ea);
        vec_t v;
        v.rst_n = rst_n; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.exp_valid = ev; v.exp_count = ec; v.exp_pc = epc; v.exp_addr = ea;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b0, 1'b0, 32'd0, 1'b1);

        // Cold start, streaming
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 3));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 2, 4));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 3, 5));
        // Back-pressure from reset, then drain
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 1, 2, 0, 3));
        vecs.push_back(mk(1, 0, 0, 0, 1, 3, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 1, 4, 0, 4));
        vecs.push_back(mk(1, 0, 0, 0, 1, 4, 0, 4));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3, 1, 4));
        vecs.push_back(mk(1, 0, 0, 1, 1, 2, 2, 5));
        vecs.push_back(mk(1, 0, 0, 1, 1, 2, 3, 6));
        vecs.push_back(mk(1, 0, 0, 1, 1, 2, 4, 7));
        vecs.push_back(mk(1, 0, 0, 1, 1, 2, 5, 8));
        vecs.push_back(mk(1, 0, 0, 1, 1, 2, 6, 9));
        vecs.push_back(mk(1, 0, 0, 1, 1, 2, 7, 10));

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d_valid", i), {31'd0, fetch_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_count", i), {29'd0, count}, {29'd0, vecs[i].exp_count});
            chk($sformatf("vec%0d_addr", i), address_imem, vecs[i].exp_addr);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), fetch_pc, vecs[i].exp_pc);
                chk($sformatf("vec%0d_insn", i), fetch_insn, 32'hA000_0000 + vecs[i].exp_pc);
            end
        end

        // Redirect while a request is in flight
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (3) step();
        drive(1'b1, 1'b1, 32'h40, 1'b1);
        step();
        chk("redir_inflight_count", {29'd0, count}, 32'd0);
        chk("redir_inflight_valid", {31'd0, fetch_valid}, 32'd0);
        chk("redir_inflight_addr", address_imem, 32'h40);
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        step();
        chk("redir_inflight_gap", {31'd0, fetch_valid}, 32'd0);
        step();
        chk("redir_inflight_v0", {31'd0, fetch_valid}, 32'd1);
        chk("redir_inflight_pc0", fetch_pc, 32'h40);
        chk("redir_inflight_insn0", fetch_insn, 32'hA000_0040);
        step();
        chk("redir_inflight_pc1", fetch_pc, 32'h41);

        // Redirect with full queue and simultaneous pop
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (6) step();
        chk("full_before_redir", {29'd0, count}, 32'd4);
        drive(1'b1, 1'b1, 32'h10, 1'b1);
        step();
        chk("full_redir_count", {29'd0, count}, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (2) step();
        chk("full_redir_valid", {31'd0, fetch_valid}, 32'd1);
        chk("full_redir_pc", fetch_pc, 32'h10);

        // Reset mid-operation with three entries held
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (4) step();
        chk("midrst_pre_count", {29'd0, count}, 32'd3);
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        step();
        chk("midrst_count", {29'd0, count}, 32'd0);
        chk("midrst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("midrst_addr", address_imem, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (2) step();
        chk("midrst_restart_pc", fetch_pc, 32'd0);

        // PC wrap
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (2) step();
        chk("wrap_pc0", fetch_pc, 32'hFFFF_FFFF);
        chk("wrap_insn0", fetch_insn, 32'h9FFF_FFFF);
        step();
        chk("wrap_pc1", fetch_pc, 32'h0000_0000);
        step();
        chk("wrap_pc2", fetch_pc, 32'h0000_0001);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) >= 2),
                  ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom(),
                  ($urandom_range(0, 99) < 65));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
